ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 140 ++++++++++++++
 tb/tb_ifetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests feeding the IF/ID register,
// with a one-entry skid buffer for stalls and a drain state for redirects during a pending fetch.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        id_valid_o,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_pc_o
);

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   logic [1:0]      state, state_n;
   logic [XLEN-1:0] pc, pc_n;
   logic [XLEN-1:0] pending, pending_n;
   logic [XLEN-1:0] buf_instr, buf_instr_n;
   logic [XLEN-1:0] buf_pc, buf_pc_n;
   logic            req, req_n;
   logic            valid, valid_n;
   logic [XLEN-1:0] instr, instr_n;
   logic [XLEN-1:0] dpc, dpc_n;

   logic            ack;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_inc;
   logic            unused_target_bits;

   // An ack only counts while a request is actually on the bus.
   assign ack                = imem_ack_i & req;
   assign target             = {redirect_pc_i[XLEN-1:2], 2'b00};
   assign pc_inc             = pc + XLEN'(4);
   assign unused_target_bits = ^redirect_pc_i[1:0];

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      pending_n   = pending;
      buf_instr_n = buf_instr;
      buf_pc_n    = buf_pc;
      valid_n     = valid;
      instr_n     = instr;
      dpc_n       = dpc;
      case (state)
         S_RUN: begin
            if (redirect_i) begin
               valid_n = 1'b0;
               if (ack || !req) begin
                  pc_n = target;
               end else begin
                  pending_n = target;
                  state_n   = S_DRAIN;
               end
            end else if (ack) begin
               pc_n = pc_inc;
               if (!stall_i) begin
                  valid_n = 1'b1;
                  instr_n = imem_rdata_i;
                  dpc_n   = pc;
               end else begin
                  buf_instr_n = imem_rdata_i;
                  buf_pc_n    = pc;
                  state_n     = S_FULL;
               end
            end else if (!stall_i) begin
               valid_n = 1'b0;
            end
         end
         S_DRAIN: begin
            // Stale response is dropped; the newest redirect target wins.
            valid_n = 1'b0;
            if (redirect_i) pending_n = target;
            if (ack) begin
               pc_n    = redirect_i ? target : pending;
               state_n = S_RUN;
            end
         end
         S_FULL: begin
            if (redirect_i) begin
               valid_n = 1'b0;
               pc_n    = target;
               state_n = S_RUN;
            end else if (!stall_i) begin
               valid_n = 1'b1;
               instr_n = buf_instr;
               dpc_n   = buf_pc;
               state_n = S_RUN;
            end
         end
         default: begin
            state_n = S_RUN;
            valid_n = 1'b0;
         end
      endcase
      req_n = (state_n != S_FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_RUN;
         pc        <= RESET_PC;
         pending   <= '0;
         buf_instr <= '0;
         buf_pc    <= '0;
         req       <= 1'b0;
         valid     <= 1'b0;
         instr     <= '0;
         dpc       <= '0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         pending   <= pending_n;
         buf_instr <= buf_instr_n;
         buf_pc    <= buf_pc_n;
         req       <= req_n;
         valid     <= valid_n;
         instr     <= instr_n;
         dpc       <= dpc_n;
      end
   end

   assign imem_req_o  = req;
   assign imem_addr_o = pc;
   assign id_valid_o  = valid;
   assign id_instr_o  = instr;
   assign id_pc_o     = dpc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a memory model that returns the address as data
// after a programmable number of wait cycles.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic        id_valid_o;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_o;

   int total = 0;
   int bad   = 0;
   int lat   = 0;
   logic [3:0] cnt = '0;

   ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .id_valid_o    (id_valid_o),
      .id_instr_o    (id_instr_o),
      .id_pc_o       (id_pc_o)
   );

   always #5 clk = ~clk;

   // Memory: ack once the request has waited lat cycles (lat=0 is zero-wait).
   assign imem_ack_i   = imem_req_o && (int'(cnt) >= lat);
   assign imem_rdata_i = imem_addr_o;
   always @(posedge clk) cnt <= (imem_req_o && !imem_ack_i) ? cnt + 4'd1 : 4'd0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; lat = 0;
      tick(); tick();
      total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%0h want=0", imem_req_o); end
      total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", id_valid_o); end
      total++; if (id_instr_o !== 32'h0) begin bad++; $display("FAIL reset_instr got=%0h want=0", id_instr_o); end
      total++; if (id_pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%0h want=0", id_pc_o); end
      total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%0h want=0", imem_addr_o); end
   endtask

   task automatic test_stream();
      rst_n = 1'b1;
      tick();
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || id_valid_o !== 1'b0) begin
         bad++; $display("FAIL first_req got req=%0h addr=%0h valid=%0h want 1/0/0", imem_req_o, imem_addr_o, id_valid_o); end
      for (int k = 0; k < 3; k++) begin
         tick();
         total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'(4*k) || id_instr_o !== 32'(4*k)) begin
            bad++; $display("FAIL stream_%0d got valid=%0h pc=%0h instr=%0h want 1/%0h/%0h", k, id_valid_o, id_pc_o, id_instr_o, 4*k, 4*k); end
      end
      total++; if (imem_addr_o !== 32'hC) begin bad++; $display("FAIL stream_addr got=%0h want=c", imem_addr_o); end
   endtask

   task automatic test_stall();
      stall_i = 1'b1;
      tick();
      total++; if (imem_req_o !== 1'b0 || id_pc_o !== 32'h8 || id_valid_o !== 1'b1) begin
         bad++; $display("FAIL stall_a got req=%0h pc=%0h valid=%0h want 0/8/1", imem_req_o, id_pc_o, id_valid_o); end
      tick();
      total++; if (imem_req_o !== 1'b0 || id_pc_o !== 32'h8) begin
         bad++; $display("FAIL stall_b got req=%0h pc=%0h want 0/8", imem_req_o, id_pc_o); end
      tick();
      total++; if (id_pc_o !== 32'h8 || id_valid_o !== 1'b1) begin
         bad++; $display("FAIL stall_c got pc=%0h valid=%0h want 8/1", id_pc_o, id_valid_o); end
      stall_i = 1'b0;
      tick();
      total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'hC || id_instr_o !== 32'hC || imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin
         bad++; $display("FAIL stall_release got valid=%0h pc=%0h instr=%0h req=%0h addr=%0h want 1/c/c/1/10", id_valid_o, id_pc_o, id_instr_o, imem_req_o, imem_addr_o); end
      tick();
      total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h10) begin
         bad++; $display("FAIL stall_next got valid=%0h pc=%0h want 1/10", id_valid_o, id_pc_o); end
   endtask

   task automatic test_redirect_drain();
      redirect_i = 1'b1; redirect_pc_i = 32'h20;
      tick();
      total++; if (id_valid_o !== 1'b0 || imem_addr_o !== 32'h20) begin
         bad++; $display("FAIL redir_ack got valid=%0h addr=%0h want 0/20", id_valid_o, imem_addr_o); end
      lat = 2; redirect_pc_i = 32'h100;
      tick();
      redirect_i = 1'b0;
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h20 || id_valid_o !== 1'b0) begin
         bad++; $display("FAIL drain_1 got req=%0h addr=%0h valid=%0h want 1/20/0", imem_req_o, imem_addr_o, id_valid_o); end
      tick();
      total++; if (imem_addr_o !== 32'h20 || id_valid_o !== 1'b0) begin
         bad++; $display("FAIL drain_2 got addr=%0h valid=%0h want 20/0", imem_addr_o, id_valid_o); end
      tick();
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || id_valid_o !== 1'b0) begin
         bad++; $display("FAIL drain_done got req=%0h addr=%0h valid=%0h want 1/100/0", imem_req_o, imem_addr_o, id_valid_o); end
      for (int k = 0; k < 2; k++) begin
         tick();
         total++; if (id_valid_o !== 1'b0) begin bad++; $display("FAIL drain_wait_%0d got valid=%0h want 0", k, id_valid_o); end
      end
      tick();
      total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h100 || id_instr_o !== 32'h100) begin
         bad++; $display("FAIL drain_target got valid=%0h pc=%0h instr=%0h want 1/100/100", id_valid_o, id_pc_o, id_instr_o); end
      lat = 0;
   endtask

   task automatic test_redirect_full();
      stall_i = 1'b1;
      tick();
      total++; if (imem_req_o !== 1'b0 || id_valid_o !== 1'b1 || id_pc_o !== 32'h100) begin
         bad++; $display("FAIL full_enter got req=%0h valid=%0h pc=%0h want 0/1/100", imem_req_o, id_valid_o, id_pc_o); end
      redirect_i = 1'b1; redirect_pc_i = 32'h200;
      tick();
      total++; if (id_valid_o !== 1'b0 || imem_addr_o !== 32'h200 || imem_req_o !== 1'b1) begin
         bad++; $display("FAIL full_redir got valid=%0h addr=%0h req=%0h want 0/200/1", id_valid_o, imem_addr_o, imem_req_o); end
      stall_i = 1'b0; redirect_i = 1'b0;
      tick();
      total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h200) begin
         bad++; $display("FAIL full_target got valid=%0h pc=%0h want 1/200", id_valid_o, id_pc_o); end
   endtask

   task automatic test_wrap();
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
      tick();
      redirect_i = 1'b0;
      total++; if (imem_addr_o !== 32'hFFFF_FFFC || id_valid_o !== 1'b0) begin
         bad++; $display("FAIL wrap_align got addr=%0h valid=%0h want fffffffc/0", imem_addr_o, id_valid_o); end
      tick();
      total++; if (id_pc_o !== 32'hFFFF_FFFC || imem_addr_o !== 32'h0) begin
         bad++; $display("FAIL wrap_inc got pc=%0h addr=%0h want fffffffc/0", id_pc_o, imem_addr_o); end
      tick();
      total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0) begin
         bad++; $display("FAIL wrap_zero got valid=%0h pc=%0h want 1/0", id_valid_o, id_pc_o); end
   endtask

   task automatic test_reset_drain();
      lat = 2; redirect_i = 1'b1; redirect_pc_i = 32'h300;
      tick();
      redirect_i = 1'b0;
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || id_valid_o !== 1'b0) begin
         bad++; $display("FAIL rd_drain got req=%0h addr=%0h valid=%0h want 1/4/0", imem_req_o, imem_addr_o, id_valid_o); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_instr_o !== 32'h0) begin
         bad++; $display("FAIL rd_async got req=%0h addr=%0h valid=%0h pc=%0h instr=%0h want 0/0/0/0/0", imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_instr_o); end
      tick(); tick();
      lat = 0; rst_n = 1'b1;
      tick();
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
         bad++; $display("FAIL rd_restart got req=%0h addr=%0h want 1/0", imem_req_o, imem_addr_o); end
      tick();
      total++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0) begin
         bad++; $display("FAIL rd_first got valid=%0h pc=%0h want 1/0", id_valid_o, id_pc_o); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drain();
      test_redirect_full();
      test_wrap();
      test_reset_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
